inst_fetch_buffer: RTL and testbench

Instruction fetch buffer for the five-stage RISC-V core: generates sequential fetch addresses to the L1 instruction memory and buffers returned instructions in order. It presents the head instruction, its PC and PC+4 on the IF side of the IF/ID pipeline register, which feeds the ID decode datapath. It absorbs instruction-memory latency and ID back-pressure, and it discards stale fetches on a branch/jump redirect from EX.

---
 rtl/inst_fetch_buffer_if.sv | 31 +++
 rtl/inst_fetch_buffer.sv | 138 +++++++++++++
 tb/tb_inst_fetch_buffer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_buffer_if.sv
// Fetch-side bundle: L1 instruction-memory request/response, EX redirect,
// hazard stall and the IF half of the IF/ID register.
interface inst_fetch_buffer_if #(
  parameter int INST_WIDTH      = 32,
  parameter int INST_ADDR_WIDTH = 32
);
  logic                       imem_req_valid;
  logic [INST_ADDR_WIDTH-1:0] imem_req_addr;
  logic                       imem_req_ready;
  logic                       imem_resp_valid;
  logic [INST_WIDTH-1:0]      imem_resp_inst;
  logic                       redirect_valid;
  logic [INST_ADDR_WIDTH-1:0] redirect_pc;
  logic                       stall_IF;
  logic                       inst_valid_IF;
  logic [INST_WIDTH-1:0]      INST_IF;
  logic [INST_ADDR_WIDTH-1:0] PC_IF;
  logic [INST_ADDR_WIDTH-1:0] PC_plus_4_IF;

  // master: the fetch buffer itself
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid_IF, INST_IF, PC_IF, PC_plus_4_IF,
    input  imem_req_ready, imem_resp_valid, imem_resp_inst, redirect_valid, redirect_pc, stall_IF
  );

  // slave: the surrounding memory, EX stage and hazard unit
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid_IF, INST_IF, PC_IF, PC_plus_4_IF,
    output imem_req_ready, imem_resp_valid, imem_resp_inst, redirect_valid, redirect_pc, stall_IF
  );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: sequential fetch generation, in-order queue of
// {inst, pc}, credit-limited requests and redirect-time dropping of stale fetches.
module inst_fetch_buffer #(
  parameter int                         INST_WIDTH      = 32,
  parameter int                         INST_ADDR_WIDTH = 32,
  parameter int                         DEPTH           = 4,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input logic                 clk,
  input logic                 rst,
  inst_fetch_buffer_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [INST_WIDTH-1:0]      NOP  = INST_WIDTH'(32'h0000_0013);
  localparam logic [INST_ADDR_WIDTH-1:0] FOUR = INST_ADDR_WIDTH'(4);

  logic [INST_ADDR_WIDTH-1:0] fetch_pc_reg;
  logic [INST_ADDR_WIDTH-1:0] resp_pc_reg;
  logic [PW-1:0]              rd_ptr_reg;
  logic [PW-1:0]              wr_ptr_reg;
  logic [CW-1:0]              count_reg;
  logic [CW-1:0]              inflight_reg;
  logic [CW-1:0]              drop_reg;

  logic [INST_WIDTH-1:0]      inst_mem [DEPTH];
  logic [INST_ADDR_WIDTH-1:0] pc_mem   [DEPTH];

  logic                       head_valid_reg;
  logic [INST_WIDTH-1:0]      head_inst_reg;
  logic [INST_ADDR_WIDTH-1:0] head_pc_reg;
  logic [INST_ADDR_WIDTH-1:0] head_pc4_reg;

  logic [CW:0]                credits_used;
  logic                       req_valid;
  logic                       req_fire;
  logic                       resp_eff;
  logic                       drop_resp;
  logic                       push;
  logic                       pop;
  logic [CW-1:0]              count_after_pop;
  logic [PW-1:0]              next_rd_ptr;
  logic [INST_WIDTH-1:0]      next_mem_inst;
  logic [INST_ADDR_WIDTH-1:0] next_mem_pc;

  // Credits count queued entries plus every outstanding request, stale ones
  // included, so a response can always be pushed without a full check.
  always_comb begin
    credits_used    = {1'b0, count_reg} + {1'b0, inflight_reg};
    req_valid       = !rst && !bus.redirect_valid && (credits_used < (CW+1)'(DEPTH));
    req_fire        = req_valid && bus.imem_req_ready;
    resp_eff        = bus.imem_resp_valid && (inflight_reg != '0);
    drop_resp       = resp_eff && (drop_reg != '0);
    push            = resp_eff && (drop_reg == '0) && !bus.redirect_valid;
    pop             = head_valid_reg && !bus.stall_IF && !bus.redirect_valid;
    count_after_pop = count_reg - CW'(pop);
    next_rd_ptr     = rd_ptr_reg + PW'(pop);
    next_mem_inst   = inst_mem[next_rd_ptr];
    next_mem_pc     = pc_mem[next_rd_ptr];
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_reg;
  assign bus.inst_valid_IF  = head_valid_reg;
  assign bus.INST_IF        = head_inst_reg;
  assign bus.PC_IF          = head_pc_reg;
  assign bus.PC_plus_4_IF   = head_pc4_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_reg] <= bus.imem_resp_inst;
      pc_mem[wr_ptr_reg]   <= resp_pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg   <= RESET_PC;
      resp_pc_reg    <= RESET_PC;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      inflight_reg   <= '0;
      drop_reg       <= '0;
      head_valid_reg <= 1'b0;
      head_inst_reg  <= NOP;
      head_pc_reg    <= '0;
      head_pc4_reg   <= '0;
    end else begin
      inflight_reg <= inflight_reg + CW'(req_fire) - CW'(resp_eff);
      if (bus.redirect_valid) begin
        // Everything still outstanding after this edge belongs to the old path.
        fetch_pc_reg   <= bus.redirect_pc;
        resp_pc_reg    <= bus.redirect_pc;
        drop_reg       <= inflight_reg - CW'(resp_eff);
        count_reg      <= '0;
        rd_ptr_reg     <= '0;
        wr_ptr_reg     <= '0;
        head_valid_reg <= 1'b0;
        head_inst_reg  <= NOP;
        head_pc_reg    <= '0;
        head_pc4_reg   <= '0;
      end else begin
        if (req_fire)  fetch_pc_reg <= fetch_pc_reg + FOUR;
        if (drop_resp) drop_reg     <= drop_reg - CW'(1);
        if (push) begin
          resp_pc_reg <= resp_pc_reg + FOUR;
          wr_ptr_reg  <= wr_ptr_reg + PW'(1);
        end
        count_reg  <= count_after_pop + CW'(push);
        rd_ptr_reg <= next_rd_ptr;
        // Head registers are loaded with whatever will sit at the front next cycle.
        if (count_after_pop != '0) begin
          head_valid_reg <= 1'b1;
          head_inst_reg  <= next_mem_inst;
          head_pc_reg    <= next_mem_pc;
          head_pc4_reg   <= next_mem_pc + FOUR;
        end else if (push) begin
          head_valid_reg <= 1'b1;
          head_inst_reg  <= bus.imem_resp_inst;
          head_pc_reg    <= resp_pc_reg;
          head_pc4_reg   <= resp_pc_reg + FOUR;
        end else begin
          head_valid_reg <= 1'b0;
          head_inst_reg  <= NOP;
          head_pc_reg    <= '0;
          head_pc4_reg   <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.imem_resp_valid && (inflight_reg == '0)));
    end
  end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer: directed scenarios plus random traffic against a
// queue-level model of the fetch buffer and an in-order variable-latency imem.
module tb_inst_fetch_buffer;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; bit stale; } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_buffer_if #(.INST_WIDTH(32), .INST_ADDR_WIDTH(32)) ifc ();

  inst_fetch_buffer #(
    .INST_WIDTH(32), .INST_ADDR_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  pend_t       pend[$];
  out_t        mo[$];
  logic [31:0] mq[$];
  logic [31:0] m_fetch;
  bit          m_init = 1'b0;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F13;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic step(input bit r, input bit rdy, input bit stl, input bit rv,
                      input logic [31:0] rpc, input bit stray);
    bit   exp_req;
    bit   resp_eff;
    out_t o;
    int   due;
    @(posedge clk);
    #1;
    rst                 = r;
    ifc.imem_req_ready  = rdy;
    ifc.stall_IF        = stl;
    ifc.redirect_valid  = rv;
    ifc.redirect_pc     = rpc;
    ifc.imem_resp_valid = 1'b0;
    ifc.imem_resp_inst  = $urandom;
    if (r) begin
      pend.delete();
      last_due = cyc;
      ifc.imem_resp_valid = stray;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      ifc.imem_resp_valid = 1'b1;
      ifc.imem_resp_inst  = inst_of(pend[0].addr);
      void'(pend.pop_front());
    end
    @(negedge clk);

    exp_req = !r && !rv && (mq.size() + mo.size() < DEPTH);
    if (r || m_init) check1("req_valid", ifc.imem_req_valid, exp_req);
    if (m_init) begin
      check32("req_addr", ifc.imem_req_addr, m_fetch);
      if (mq.size() > 0) begin
        check1("inst_valid", ifc.inst_valid_IF, 1'b1);
        check32("inst", ifc.INST_IF, inst_of(mq[0]));
        check32("pc", ifc.PC_IF, mq[0]);
        check32("pc_plus_4", ifc.PC_plus_4_IF, mq[0] + 32'd4);
      end else begin
        check1("inst_valid", ifc.inst_valid_IF, 1'b0);
        check32("inst", ifc.INST_IF, NOP);
        check32("pc", ifc.PC_IF, 32'h0);
        check32("pc_plus_4", ifc.PC_plus_4_IF, 32'h0);
      end
    end

    if (!r && ifc.imem_req_valid && rdy) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      pend.push_back('{ifc.imem_req_addr, due});
      last_due = due;
    end

    if (!r && ifc.inst_valid_IF && !stl && !rv)
      $display("cycle %0d: consume pc=%h inst=%h", cyc, ifc.PC_IF, ifc.INST_IF);

    if (r) begin
      mq.delete();
      mo.delete();
      m_fetch = RESET_PC;
      m_init  = 1'b1;
    end else if (m_init) begin
      resp_eff = ifc.imem_resp_valid && (mo.size() > 0);
      if (rv) begin
        if (resp_eff) void'(mo.pop_front());
        mq.delete();
        foreach (mo[i]) mo[i].stale = 1'b1;
        m_fetch = rpc;
      end else begin
        if (mq.size() > 0 && !stl) void'(mq.pop_front());
        if (resp_eff) begin
          o = mo.pop_front();
          if (!o.stale) mq.push_back(o.pc);
        end
        if (exp_req && rdy) begin
          mo.push_back('{m_fetch, 1'b0});
          m_fetch = m_fetch + 32'd4;
        end
      end
    end
    cyc++;
  endtask

  initial begin
    int          nreq;
    bit          got;
    logic [31:0] cap;
    logic [31:0] seen [3];
    logic [31:0] seen4 [3];
    int          ns;
    bit          r, rv, stl, rdy;
    logic [31:0] rpc;

    ifc.imem_req_ready  = 1'b0;
    ifc.imem_resp_valid = 1'b0;
    ifc.imem_resp_inst  = '0;
    ifc.redirect_valid  = 1'b0;
    ifc.redirect_pc     = '0;
    ifc.stall_IF        = 1'b0;

    // Streaming at L=1 from reset.
    lat = 1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check1("p1_first_req_valid", ifc.imem_req_valid, 1'b1);
    check32("p1_first_req_addr", ifc.imem_req_addr, 32'h0);
    check1("p1_reset_inst_valid", ifc.inst_valid_IF, 1'b0);
    check32("p1_reset_inst", ifc.INST_IF, 32'h0000_0013);
    check32("p1_reset_pc", ifc.PC_IF, 32'h0);
    check32("p1_reset_pc4", ifc.PC_plus_4_IF, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check32("p1_second_req_addr", ifc.imem_req_addr, 32'h4);
    check1("p1_not_yet_valid", ifc.inst_valid_IF, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check1("p1_stream_valid", ifc.inst_valid_IF, 1'b1);
      check32("p1_stream_pc", ifc.PC_IF, 32'(k * 4));
      check32("p1_stream_pc4", ifc.PC_plus_4_IF, 32'(k * 4 + 4));
      check32("p1_stream_inst", ifc.INST_IF, inst_of(32'(k * 4)));
    end
    repeat (12) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Held stall fills the credits, then drains in order.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    nreq = 0;
    repeat (10) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      if (ifc.imem_req_valid) nreq++;
    end
    check32("p2_req_count", 32'(nreq), 32'd4);
    check1("p2_req_blocked", ifc.imem_req_valid, 1'b0);
    got = 1'b0;
    cap = 32'hDEAD_BEEF;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      if (k < 4) check32("p2_drain_pc", ifc.PC_IF, 32'(k * 4));
      if (!got && ifc.imem_req_valid) begin
        got = 1'b1;
        cap = ifc.imem_req_addr;
      end
    end
    check32("p2_resume_addr", cap, 32'h10);

    // Redirect with two requests outstanding at L=3.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    lat = 3;
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
    check1("p3_redirect_no_req", ifc.imem_req_valid, 1'b0);
    got = 1'b0;
    cap = 32'hDEAD_BEEF;
    repeat (20) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      if (!got && ifc.inst_valid_IF) begin
        got = 1'b1;
        cap = ifc.PC_IF;
      end
    end
    check32("p3_first_pc", cap, 32'h100);

    // Address wrap at the top of the space.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    lat = 1;
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    ns = 0;
    foreach (seen[i]) begin
      seen[i]  = 32'hDEAD_BEEF;
      seen4[i] = 32'hDEAD_BEEF;
    end
    repeat (12) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      if (ifc.inst_valid_IF && ns < 3) begin
        seen[ns]  = ifc.PC_IF;
        seen4[ns] = ifc.PC_plus_4_IF;
        ns++;
      end
    end
    check32("p4_pc0", seen[0], 32'hFFFF_FFF8);
    check32("p4_pc1", seen[1], 32'hFFFF_FFFC);
    check32("p4_pc2", seen[2], 32'h0000_0000);
    check32("p4_pc1_plus_4", seen4[1], 32'h0000_0000);

    // Random traffic: latency, ready, stall, redirects and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      lat = $urandom_range(1, 3);
      r   = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      stl = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF8;
      step(r, rdy, stl, rv, rpc, 1'(($urandom_range(0, 1))));
    end

    // Reset with a loaded queue and requests in flight, plus a stray response.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    lat = 2;
    repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check1("p6_loaded_valid", ifc.inst_valid_IF, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check1("p6_after_rst_valid", ifc.inst_valid_IF, 1'b0);
    check32("p6_after_rst_inst", ifc.INST_IF, 32'h0000_0013);
    check32("p6_after_rst_pc", ifc.PC_IF, 32'h0);
    check32("p6_after_rst_pc4", ifc.PC_plus_4_IF, 32'h0);
    check1("p6_after_rst_req", ifc.imem_req_valid, 1'b1);
    check32("p6_after_rst_addr", ifc.imem_req_addr, 32'h0);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check1("p6_idle_valid", ifc.inst_valid_IF, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
